// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared width helpers, error-flag struct and default sizes for
//                the parametrised FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit beyond the address carries the wrap indication.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
//  Module      : fifo_mem
//  Description : Simple dual-port storage array, one write and one read port.
//                Read is registered, or asynchronous when FIFO_FWFT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = addr_w(DEF_DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

`ifdef FIFO_FWFT_EN
   logic w_unused_rd_en;

   assign w_unused_rd_en = i_rd_en;
   assign o_rd_data      = r_mem[i_rd_addr];
`else
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;
`endif

endmodule : fifo_mem

`default_nettype wire

// File: rtl/fifo_param.sv
// ============================================================================
//  Module      : fifo_param
//  Description : Parametrised synchronous FIFO with fill count, thresholds,
//                sticky errors and flush. Define FIFO_FWFT_EN for FWFT mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      rd_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [count_w(DEPTH)-1:0] count,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      clr_err
);

   localparam int AW = addr_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = count_w(DEPTH);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   err_flags_t       r_err;
   err_flags_t       w_err_new;
   logic             w_full;
   logic             w_empty;
   logic             w_wr_acc;
   logic             w_rd_acc;
   logic [WIDTH-1:0] w_mem_rdata;

   // Same address with opposite wrap bits means the writer lapped the reader.
   assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);

   assign w_wr_acc = wr_en && !w_full;
   assign w_rd_acc = rd_en && !w_empty;

   assign w_err_new.overflow  = wr_en && w_full;
   assign w_err_new.underflow = rd_en && w_empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A fresh error outranks a clear arriving in the same cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= '0;
      end else begin
         r_err.overflow  <= w_err_new.overflow  || (r_err.overflow  && !clr_err);
         r_err.underflow <= w_err_new.underflow || (r_err.underflow && !clr_err);
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk     (clock),
      .i_wr_en   (w_wr_acc && !flush),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (wr_data),
      .i_rd_en   (w_rd_acc && !flush),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (w_mem_rdata)
   );

`ifdef FIFO_FWFT_EN
   assign rd_valid = !w_empty;
   assign rd_data  = w_empty ? '0 : w_mem_rdata;
`else
   logic r_rd_valid;
   logic r_rd_seen;

   // The array has no reset, so its read register is masked until first use.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_valid <= 1'b0;
         r_rd_seen  <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc && !flush;
         if (w_rd_acc && !flush) begin
            r_rd_seen <= 1'b1;
         end
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_seen ? w_mem_rdata : '0;
`endif

   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = r_count;
   assign almost_full  = (int'(r_count) >= AF_THRESH);
   assign almost_empty = (int'(r_count) <= AE_THRESH);
   assign overflow     = r_err.overflow;
   assign underflow    = r_err.underflow;

endmodule : fifo_param

`default_nettype wire
